// File: rtl/rect_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rect_pkg
//  Description : Shared definitions for the rectangle list renderer: default
//                field widths, table-entry layout helpers and FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package rect_pkg;

    // Default field widths of one table entry
    localparam int c_def_x_w = 8;
    localparam int c_def_y_w = 7;
    localparam int c_def_c_w = 3;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SCAN = 3'd2,
        ST_NEXT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // One entry is packed as {colour, h, w, y, x} with x in the LSBs
    function automatic int entry_width(input int x_w, input int y_w, input int c_w);
        return 2 * x_w + 2 * y_w + c_w;
    endfunction

    function automatic int off_y(input int x_w);
        return x_w;
    endfunction

    function automatic int off_w(input int x_w, input int y_w);
        return x_w + y_w;
    endfunction

    function automatic int off_h(input int x_w, input int y_w);
        return 2 * x_w + y_w;
    endfunction

    function automatic int off_c(input int x_w, input int y_w);
        return 2 * x_w + 2 * y_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rect_scan.sv
`default_nettype none
// ============================================================================
//  Module      : rect_scan
//  Description : Raster counters for one rectangle. Walks xc/yc row-major,
//                flags the last pixel, forms the screen coordinate and (with
//                RECT_CLIP_EN defined) flags pixels that fall off screen.
//  Build macro : RECT_CLIP_EN - enable off-screen pixel suppression
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_scan
    import rect_pkg::*;
#(
    parameter int X_W      = c_def_x_w,
    parameter int Y_W      = c_def_y_w,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           load,
    input  logic           adv,
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    output logic [X_W-1:0] xc,
    output logic [Y_W-1:0] yc,
    output logic           last,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic           clipped
);

    logic [X_W-1:0] r_xc;
    logic [Y_W-1:0] r_yc;
    logic           w_row_end;
    logic           w_col_end;

    assign w_row_end = (r_xc == w - X_W'(1));
    assign w_col_end = (r_yc == h - Y_W'(1));
    assign last      = w_row_end && w_col_end;
    assign xc        = r_xc;
    assign yc        = r_yc;

    // Row-major raster counters, cleared when a new entry is loaded
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_xc <= '0;
            r_yc <= '0;
        end else if (load) begin
            r_xc <= '0;
            r_yc <= '0;
        end else if (adv) begin
            if (w_row_end) begin
                r_xc <= '0;
                r_yc <= r_yc + Y_W'(1);
            end else begin
                r_xc <= r_xc + X_W'(1);
            end
        end
    end

`ifdef RECT_CLIP_EN
    // One extra bit so a sum past the field range is still seen as off screen
    localparam logic [X_W:0] c_screen_w = SCREEN_W[X_W:0];
    localparam logic [Y_W:0] c_screen_h = SCREEN_H[Y_W:0];

    logic [X_W:0] w_sum_x;
    logic [Y_W:0] w_sum_y;

    assign w_sum_x = {1'b0, x} + {1'b0, r_xc};
    assign w_sum_y = {1'b0, y} + {1'b0, r_yc};
    assign pix_x   = w_sum_x[X_W-1:0];
    assign pix_y   = w_sum_y[Y_W-1:0];
    assign clipped = (w_sum_x >= c_screen_w) || (w_sum_y >= c_screen_h);
`else
    // Coordinates simply wrap at the field width; nothing is suppressed
    logic w_unused_screen;

    assign pix_x           = x + r_xc;
    assign pix_y           = y + r_yc;
    assign clipped         = 1'b0;
    assign w_unused_screen = ^{SCREEN_W[0], SCREEN_H[0]};
`endif

endmodule
`default_nettype wire

// File: rtl/rect_list_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : rect_list_renderer
//  Description : Walks a table of NUM_RECTS rectangles and streams their
//                pixels, one per accepted cycle, over a valid/ready port.
//                A run begins on start and ends with a one-cycle done pulse.
//  Build macro : RECT_CLIP_EN - suppress pixels outside SCREEN_W x SCREEN_H
//  Revision    : 1.0 - initial release
// ============================================================================
module rect_list_renderer
    import rect_pkg::*;
#(
    parameter int X_W       = c_def_x_w,
    parameter int Y_W       = c_def_y_w,
    parameter int C_W       = c_def_c_w,
    parameter int NUM_RECTS = 6,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    localparam int IDX_W    = (NUM_RECTS > 1) ? $clog2(NUM_RECTS) : 1,
    localparam int ENTRY_W  = entry_width(X_W, Y_W, C_W)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [NUM_RECTS-1:0]         rect_en,
    input  logic [NUM_RECTS*ENTRY_W-1:0] rect_cfg,
    input  logic                         pix_ready,
    output logic                         pix_valid,
    output logic [X_W-1:0]               pix_x,
    output logic [Y_W-1:0]               pix_y,
    output logic [C_W-1:0]               pix_colour,
    output logic [IDX_W-1:0]             cur_idx,
    output logic                         busy,
    output logic                         done
);

    localparam int               c_off_y    = off_y(X_W);
    localparam int               c_off_w    = off_w(X_W, Y_W);
    localparam int               c_off_h    = off_h(X_W, Y_W);
    localparam int               c_off_c    = off_c(X_W, Y_W);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_RECTS - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [NUM_RECTS-1:0] r_en_q;
    logic [X_W-1:0]       r_x;
    logic [Y_W-1:0]       r_y;
    logic [X_W-1:0]       r_w;
    logic [Y_W-1:0]       r_h;
    logic [C_W-1:0]       r_colour;

    logic                 w_en_latch;
    logic                 w_idx_clr;
    logic                 w_idx_inc;
    logic                 w_cfg_latch;
    logic                 w_scan_load;
    logic                 w_scan_adv;

    logic [ENTRY_W-1:0]   w_entries [NUM_RECTS];
    logic [ENTRY_W-1:0]   w_entry;
    logic [X_W-1:0]       w_cfg_x;
    logic [Y_W-1:0]       w_cfg_y;
    logic [X_W-1:0]       w_cfg_w;
    logic [Y_W-1:0]       w_cfg_h;
    logic [C_W-1:0]       w_cfg_c;

    logic [X_W-1:0]       w_xc;
    logic [Y_W-1:0]       w_yc;
    logic                 w_scan_last;
    logic [X_W-1:0]       w_scan_x;
    logic [Y_W-1:0]       w_scan_y;
    logic                 w_scan_clipped;
    logic                 w_in_scan;
    logic                 w_unused_scan;

    // Unpack the flat configuration bus into one word per entry
    for (genvar gi = 0; gi < NUM_RECTS; gi++) begin : g_entry
        assign w_entries[gi] = rect_cfg[gi*ENTRY_W +: ENTRY_W];
    end

    assign w_entry = w_entries[r_idx];
    assign w_cfg_x = w_entry[0       +: X_W];
    assign w_cfg_y = w_entry[c_off_y +: Y_W];
    assign w_cfg_w = w_entry[c_off_w +: X_W];
    assign w_cfg_h = w_entry[c_off_h +: Y_W];
    assign w_cfg_c = w_entry[c_off_c +: C_W];

    rect_scan #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_scan (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (w_scan_load),
        .adv     (w_scan_adv),
        .x       (r_x),
        .y       (r_y),
        .w       (r_w),
        .h       (r_h),
        .xc      (w_xc),
        .yc      (w_yc),
        .last    (w_scan_last),
        .pix_x   (w_scan_x),
        .pix_y   (w_scan_y),
        .clipped (w_scan_clipped)
    );

    // Raw counter values are available for debug but not needed here
    assign w_unused_scan = ^{w_xc, w_yc};

    // State register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes; abort overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        w_en_latch  = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        w_cfg_latch = 1'b0;
        w_scan_load = 1'b0;
        w_scan_adv  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_en_latch  = 1'b1;
                    w_idx_clr   = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_cfg_latch = 1'b1;
                w_scan_load = 1'b1;
                if (!r_en_q[r_idx] || (w_cfg_w == '0) || (w_cfg_h == '0)) begin
                    w_state_nxt = ST_NEXT;
                end else begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Suppressed pixels move on without waiting for the sink
                w_scan_adv = w_scan_clipped || pix_ready;
                if (w_scan_adv && w_scan_last) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (r_idx == c_last_idx) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_idx_inc   = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
            w_en_latch  = 1'b0;
            w_idx_clr   = 1'b0;
            w_idx_inc   = 1'b0;
            w_cfg_latch = 1'b0;
            w_scan_load = 1'b0;
            w_scan_adv  = 1'b0;
        end
    end

    // Entry index, enable snapshot and working copy of the current entry
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_idx    <= '0;
            r_en_q   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_colour <= '0;
        end else begin
            if (w_en_latch) begin
                r_en_q <= rect_en;
            end
            if (w_idx_clr) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_cfg_latch) begin
                r_x      <= w_cfg_x;
                r_y      <= w_cfg_y;
                r_w      <= w_cfg_w;
                r_h      <= w_cfg_h;
                r_colour <= w_cfg_c;
            end
        end
    end

    // Pixel outputs are forced to zero outside SCAN so idle/reset reads 0
    assign w_in_scan  = (r_state == ST_SCAN);
    assign pix_valid  = w_in_scan && !w_scan_clipped;
    assign pix_x      = w_in_scan ? w_scan_x : '0;
    assign pix_y      = w_in_scan ? w_scan_y : '0;
    assign pix_colour = w_in_scan ? r_colour : '0;
    assign cur_idx    = r_idx;
    assign busy       = (r_state == ST_LOAD) || (r_state == ST_SCAN) || (r_state == ST_NEXT);
    assign done       = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_rect_list_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rect_list_renderer
//  Description : Self-checking bench for rect_list_renderer (NUM_RECTS=3).
//                Table of run vectors plus hand-written abort/reset cases;
//                expected pixels are queued when a run starts and popped on
//                every accepted handshake.
//  Build macro : RECT_CLIP_EN - selects clipped expectations
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rect_list_renderer;

    localparam int X_W     = 8;
    localparam int Y_W     = 7;
    localparam int C_W     = 3;
    localparam int N       = 3;
    localparam int ENTRY_W = 2 * X_W + 2 * Y_W + C_W;
    localparam int CFG_W   = N * ENTRY_W;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               start;
    logic               abort;
    logic [N-1:0]       rect_en;
    logic [CFG_W-1:0]   rect_cfg;
    logic               pix_ready;
    logic               pix_valid;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [C_W-1:0]     pix_colour;
    logic [1:0]         cur_idx;
    logic               busy;
    logic               done;

    rect_list_renderer #(
        .X_W       (X_W),
        .Y_W       (Y_W),
        .C_W       (C_W),
        .NUM_RECTS (N),
        .SCREEN_W  (160),
        .SCREEN_H  (120)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .rect_en    (rect_en),
        .rect_cfg   (rect_cfg),
        .pix_ready  (pix_ready),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .cur_idx    (cur_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic [1:0] idx;
    } pix_t;

    typedef struct {
        string        name;
        logic [N-1:0] en;
        logic [CFG_W-1:0] cfg;
        bit           bp;
        bit           restart;
        int           exp_pix;
        int           exp_cyc;
    } vec_t;

    pix_t        exp_q[$];
    vec_t        vq[$];
    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    logic [3:0]  idx_seen = '0;
    bit          bp_mode = 0;
    int          rdy_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [20:0] prev_out = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [ENTRY_W-1:0] mk_entry(input int x, input int y, input int w,
                                                    input int h, input int c);
        logic [7:0] lx = x[7:0];
        logic [6:0] ly = y[6:0];
        logic [7:0] lw = w[7:0];
        logic [6:0] lh = h[6:0];
        logic [2:0] lc = c[2:0];
        return {lc, lh, lw, ly, lx};
    endfunction

    // Reference model: expected pixel stream of a whole run, in order
    task automatic push_expected(input logic [N-1:0] en, input logic [CFG_W-1:0] cfg);
        for (int i = 0; i < N; i++) begin
            logic [ENTRY_W-1:0] e;
            int ex, ey, ew, eh, ec, ux, uy;
            pix_t p;
            e  = cfg[i*ENTRY_W +: ENTRY_W];
            ex = int'(e[7:0]);
            ey = int'(e[14:8]);
            ew = int'(e[22:15]);
            eh = int'(e[29:23]);
            ec = int'(e[32:30]);
            if (en[i]) begin
                for (int yc = 0; yc < eh; yc++) begin
                    for (int xc = 0; xc < ew; xc++) begin
                        ux = ex + xc;
                        uy = ey + yc;
`ifdef RECT_CLIP_EN
                        if (ux >= 160 || uy >= 120) continue;
`endif
                        p.x   = ux[7:0];
                        p.y   = uy[6:0];
                        p.c   = ec[2:0];
                        p.idx = i[1:0];
                        exp_q.push_back(p);
                    end
                end
            end
        end
    endtask

    // Sink readiness: always ready, or the 1,0,0 pattern under backpressure
    always @(posedge clock) begin
        #1;
        rdy_cyc++;
        pix_ready = bp_mode ? ((rdy_cyc % 3) == 0) : 1'b1;
    end

    // Monitor: scoreboard pop on each handshake, hold check while stalled
    always @(negedge clock) begin
        if (reset_n) begin
            if (busy) idx_seen[cur_idx] = 1'b1;
            if (prev_stall)
                chk("stall_hold", {pix_valid, pix_x, pix_y, pix_colour, cur_idx}, prev_out);
            if (pix_valid && pix_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: actual x=%0d y=%0d, required no pixel", pix_x, pix_y);
                end else begin
                    chk("pixel", {pix_x, pix_y, pix_colour, cur_idx}, exp_q.pop_front());
                end
            end
            prev_stall = pix_valid && !pix_ready;
            prev_out   = {pix_valid, pix_x, pix_y, pix_colour, cur_idx};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic add_vec(input string name, input logic [N-1:0] en, input logic [CFG_W-1:0] cfg,
                           input bit bp, input bit restart, input int exp_pix, input int exp_cyc);
        vec_t v;
        v.name = name; v.en = en; v.cfg = cfg; v.bp = bp; v.restart = restart;
        v.exp_pix = exp_pix; v.exp_cyc = exp_cyc;
        vq.push_back(v);
    endtask

    task automatic pulse_start();
        @(posedge clock); #1 start = 1'b1;
        @(posedge clock); #1 start = 1'b0;
    endtask

    // One full run: drive, wait for done within a budget, compare totals
    task automatic run_vec(input vec_t v);
        int  cyc;
        int  n;
        bit  got_done;
        exp_q.delete();
        hs_count = 0;
        idx_seen = '0;
        bp_mode  = v.bp;
        rect_en  = v.en;
        rect_cfg = v.cfg;
        push_expected(v.en, v.cfg);
        pulse_start();
        cyc = 0; n = 0; got_done = 0;
        while (!got_done && n < 3000) begin
            @(negedge clock);
            n++;
            if (done) begin
                got_done = 1;
                chk({v.name, "_busy_at_done"}, busy, 1'b0);
            end else if (busy) begin
                cyc++;
            end
            start = v.restart && busy && (cyc == 3);
        end
        start = 1'b0;
        chk({v.name, "_done_seen"}, got_done, 1'b1);
        if (v.exp_cyc >= 0) chk({v.name, "_busy_cycles"}, cyc, v.exp_cyc);
        chk({v.name, "_handshakes"}, hs_count, v.exp_pix);
        chk({v.name, "_queue_left"}, exp_q.size(), 0);
        chk({v.name, "_idx_seen"}, idx_seen, 4'b0111);
        @(negedge clock);
        chk({v.name, "_done_width"}, {done, busy}, 2'b00);
        bp_mode = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   n;
        bit   hit;
        int   dones;
        logic [CFG_W-1:0] single;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b1;
        rect_en = '0; rect_cfg = '0;

        single = {mk_entry(0, 0, 5, 5, 1), mk_entry(0, 0, 5, 5, 2), mk_entry(10, 5, 3, 2, 5)};

        add_vec("single", 3'b001, single, 0, 0, 6, 12);
        add_vec("backpressure", 3'b001, single, 1, 0, 6, -1);
        add_vec("skip_en", 3'b101,
                {mk_entry(100, 100, 3, 1, 3), mk_entry(50, 50, 4, 4, 2), mk_entry(0, 0, 2, 2, 1)},
                0, 0, 7, 13);
        add_vec("skip_w0", 3'b111,
                {mk_entry(30, 40, 2, 3, 6), mk_entry(20, 20, 0, 3, 4), mk_entry(1, 2, 1, 1, 7)},
                0, 0, 7, 13);
        add_vec("skip_h0", 3'b111,
                {mk_entry(7, 7, 1, 2, 2), mk_entry(60, 60, 5, 0, 4), mk_entry(5, 5, 2, 2, 3)},
                0, 0, 6, 12);
`ifdef RECT_CLIP_EN
        add_vec("clip_edge", 3'b001, {mk_entry(0, 0, 1, 1, 0), mk_entry(0, 0, 1, 1, 0),
                mk_entry(158, 119, 4, 2, 2)}, 0, 0, 2, 14);
        add_vec("wrap_edge", 3'b001, {mk_entry(0, 0, 1, 1, 0), mk_entry(0, 0, 1, 1, 0),
                mk_entry(254, 126, 4, 3, 1)}, 0, 0, 0, 18);
`else
        add_vec("clip_edge", 3'b001, {mk_entry(0, 0, 1, 1, 0), mk_entry(0, 0, 1, 1, 0),
                mk_entry(158, 119, 4, 2, 2)}, 0, 0, 8, 14);
        add_vec("wrap_edge", 3'b001, {mk_entry(0, 0, 1, 1, 0), mk_entry(0, 0, 1, 1, 0),
                mk_entry(254, 126, 4, 3, 1)}, 0, 0, 12, 18);
`endif
        add_vec("start_busy", 3'b101,
                {mk_entry(100, 100, 3, 1, 3), mk_entry(50, 50, 4, 4, 2), mk_entry(0, 0, 2, 2, 1)},
                0, 1, 7, 13);

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_outputs", {pix_valid, pix_x, pix_y, pix_colour, cur_idx, busy, done}, '0);
        reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) run_vec(vq[i]);

        // Abort mid-scan of entry 2
        exp_q.delete();
        rect_en  = 3'b111;
        rect_cfg = {mk_entry(40, 40, 5, 5, 6), mk_entry(3, 3, 1, 1, 4), mk_entry(1, 1, 2, 2, 2)};
        push_expected(rect_en, rect_cfg);
        pulse_start();
        hit = 0; n = 0;
        while (!hit && n < 200) begin
            @(negedge clock);
            n++;
            hit = (cur_idx == 2'd2) && pix_valid;
        end
        chk("abort_reached_idx2", hit, 1'b1);
        repeat (2) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_outputs", {pix_valid, busy, done}, 3'b000);
        dones = 0;
        repeat (10) begin
            @(negedge clock);
            if (done || busy) dones++;
        end
        chk("abort_stays_idle", dones, 0);
        run_vec(vq[2]);

        // Reset in the middle of a run
        exp_q.delete();
        rect_en = 3'b001;
        rect_cfg = single;
        push_expected(rect_en, rect_cfg);
        pulse_start();
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        chk("reset_mid_outputs", {pix_valid, pix_x, pix_y, pix_colour, cur_idx, busy, done}, '0);
        reset_n = 1'b1;
        exp_q.delete();
        run_vec(vq[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rect_list_renderer.md
Name: rect_list_renderer

Overview:
- Parametrised successor to the single-rectangle pixel scanner.
- Sequences a table of NUM_RECTS rectangles (position, size, colour) and streams one pixel per accepted cycle to the VGA adapter write port via a valid/ready handshake.
- Each run is started with a start pulse and ends with a done pulse.
- Replaces the hard-coded boundary/goal drawing FSM; the rink layout becomes a table supplied by the game top level.

Parameters:
- X_W, 8, x coordinate / width field bits
- Y_W, 7, y coordinate / height field bits
- C_W, 3, colour bits
- NUM_RECTS, 6, table entries (>=1)
- SCREEN_W, 160, visible columns (clip limit)
- SCREEN_H, 120, visible rows (clip limit)

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  begin a run; honoured only in IDLE
- abort  in  1  synchronous cancel; back to IDLE, no done
- rect_en  in  NUM_RECTS  per-entry enable, sampled at start
- rect_cfg  in  NUM_RECTS*(2*X_W+2*Y_W+C_W)  entry i = {colour,h,w,y,x} at slice i; must be held stable while busy
- pix_ready  in  1  sink accepts pixel this cycle
- pix_valid  out  1  pixel outputs valid
- pix_x  out  X_W  pixel column
- pix_y  out  Y_W  pixel row
- pix_colour  out  C_W  pixel colour
- cur_idx  out  clog2(NUM_RECTS)  entry being drawn
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at end of run

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE; all outputs 0; counters and index 0; takes effect immediately, including mid-run. No done is issued.
- States: IDLE, LOAD, SCAN, NEXT, DONE.
- IDLE: on start=1, latch rect_en into en_q, idx=0, go to LOAD. busy rises the following cycle.
- LOAD (1 cycle): latch entry idx fields into working registers; clear xc and yc.
  - If en_q[idx]=0, or w=0, or h=0: go to NEXT (entry skipped).
  - Otherwise go to SCAN.
- Size semantics: w and h are pixel counts. A rectangle covers x..x+w-1 and y..y+h-1, i.e. exactly w*h pixels.
- SCAN: pix_x = x+xc, pix_y = y+yc (truncated to X_W/Y_W), pix_colour = colour.
  - pix_valid=1 when the pixel is emitted (see clipping).
  - Advance only on pix_valid && pix_ready, or when the pixel is suppressed.
  - Outputs hold stable while pix_valid=1 and pix_ready=0.
  - Raster order is row-major: xc increments; at xc=w-1, xc returns to 0 and yc increments.
  - When the pixel at (w-1, h-1) advances, go to NEXT.
- NEXT (1 cycle, pix_valid=0): if idx=NUM_RECTS-1 go to DONE; else idx++ and go to LOAD.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- start while busy is ignored (no restart, no queueing).
- abort=1 in any non-IDLE state: next cycle IDLE, pix_valid=0, no done. abort has priority over all transitions; reset_n has priority over abort.
- Throughput: per enabled entry, 1 LOAD + w*h SCAN cycles (with pix_ready=1) + 1 NEXT; plus 1 DONE cycle per run.
- Overlapping entries: later index overwrites; no arbitration.

Optional Feature:
- Macro: RECT_CLIP_EN.
- Defined: a pixel whose unwrapped x+xc >= SCREEN_W or y+yc >= SCREEN_H is suppressed. pix_valid=0 for that pixel and the scanner advances in one cycle without waiting for pix_ready. Addition is done at X_W+1 / Y_W+1 bits so overflow is detected.
- Undefined: no comparison; every pixel is emitted; coordinates wrap modulo 2^X_W / 2^Y_W.

Decomposition:
- Package rect_pkg:
  - field width localparams and the entry-width expression
  - state encoding (IDLE..DONE)
  - field slice offsets within an entry
- Sub-module rect_scan: holds xc/yc counters, last-pixel detect, coordinate add and clip. Interface: load, adv, w, h → xc, yc, last.
- Top holds the sequencing FSM, idx and en_q.

Test Plan:
- Single entry x=10,y=5,w=3,h=2, pix_ready=1 → 6 pixels in order (10,5)(11,5)(12,5)(10,6)(11,6)(12,6), then done exactly 1 cycle later than NEXT; 1+6+1+1 cycles after busy rises.
- Backpressure: same entry, pix_ready toggling 1,0,0,1… → no pixel dropped or duplicated; outputs stable while stalled; 6 handshakes total.
- Skip: NUM_RECTS=3, rect_en=3'b101, entry1 w=0 also tested with en=1 → entry1 emits nothing; cur_idx passes 0,1,2; pixel count = w0*h0 + w2*h2.
- abort asserted mid-SCAN of entry 2 → pix_valid=0 next cycle, IDLE, no done. A following start redraws from idx 0.
- reset_n=0 mid-run → all outputs 0 on the next cycle. start while busy → ignored; total pixel count unchanged.
- Clip: x=158,y=119,w=4,h=2, with RECT_CLIP_EN → only (158,119),(159,119) emitted. Without it → 8 pixels; row 120 is emitted as y=120, within 7 bits.
